sram_fifo_ctrl: RTL
===================

Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives one single-port GF_SRAM_512x8 macro through its address/data/enable pins and consumes its Q outputs.
- Sits in user designs in front of the SRAM primitive. It provides valid/ready write and read streams so user logic never drives the active-low SRAM controls directly.
- Adds a 2-entry output buffer, so rd_data is first-word-fall-through.

Parameters:
- ADDR_W, 9, SRAM address width; DEPTH = 2**ADDR_W words stored in the SRAM.
- DATA_W, 8, word width; matches the SRAM D/Q width.
- ALMOST_FULL, 480, level threshold for almost_full.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write accepted this cycle when wr_valid and wr_ready are both high.
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  rd_data holds the oldest word.
- rd_ready  in  1  consumer pops the word when rd_valid and rd_ready are both high.
- rd_data  out  DATA_W  head of the output buffer.
- level  out  ADDR_W+2  words held = sram_count + inflight + obuf_count; range 0..DEPTH+2.
- almost_full  out  1  level >= ALMOST_FULL.
- sram_a  out  ADDR_W  to SRAM A8..A0.
- sram_d  out  DATA_W  to SRAM D7..D0.
- sram_wen  out  DATA_W  to SRAM WEN7..WEN0; active low.
- sram_gwen  out  1  global write enable; active low.
- sram_cen  out  1  chip enable; active low.
- sram_q  in  DATA_W  from SRAM Q7..Q0; valid in the cycle after a read edge.

Behaviour:
- State:
  - wr_ptr, rd_ptr: ADDR_W bits each; wrap modulo DEPTH.
  - sram_count: 0..DEPTH.
  - inflight: 1 bit; set when a read was issued on the previous edge.
  - obuf: 2 entries, obuf_count 0..2.
- Reset: all state cleared.
  - Outputs during and after reset: wr_ready=1, rd_valid=0, level=0, almost_full=0.
  - SRAM pins during reset: sram_cen=1, sram_gwen=1, sram_wen='1, sram_a=0, sram_d=0.
  - SRAM contents are not cleared.
- At most one SRAM operation per cycle (single port). The operation is decided combinationally in the current cycle and taken by the SRAM at the next edge.
- starve = (obuf_count + inflight == 0) && sram_count > 0.
- can_read = sram_count > 0 && obuf_count + inflight < 2.
- Arbitration, in priority order:
  1. starve → issue a read.
  2. Otherwise, wr_valid && sram_count < DEPTH → issue a write.
  3. Otherwise, can_read → issue a read.
  4. Otherwise, idle.
- wr_ready = (sram_count < DEPTH) && !starve. It is a function of state only, with no combinational path from wr_valid.
- Write operation: cen=0, gwen=0, wen=0, a=wr_ptr, d=wr_data. Then wr_ptr++ and sram_count++.
- Read operation: cen=0, gwen=1, wen='1, a=rd_ptr, d=0. Then rd_ptr++, sram_count--, inflight<=1.
- Idle: cen=1, gwen=1, wen='1, a=0, d=0.
- When inflight=1, sram_q is pushed into obuf at the next edge and inflight is cleared, unless a new read is issued in the same cycle.
- obuf:
  - Push and pop in the same cycle are legal; count is unchanged and order is preserved.
  - rd_valid = obuf_count > 0.
  - rd_data holds stable while rd_valid && !rd_ready.
- Latency: a write accepted at edge T into an empty FIFO gives rd_valid=1 after edge T+2. The read is issued at T+1 and Q is captured at T+2.
- Full: with DEPTH words in the SRAM, wr_ready=0. Maximum level is DEPTH+2.
- Overflow and underflow are impossible by construction. A pop while rd_valid=0 is ignored.
- rst asserted mid-operation: any Q return pending for an inflight read is discarded.

Decomposition:
- Package sram_fifo_pkg holds:
  - ADDR_W and DATA_W defaults, and DEPTH.
  - SRAM control constants (CEN_ON=0, GWEN_WR=0, WEN_ALL=0, WEN_NONE='1).
  - An enum for the operation: OP_IDLE, OP_RD, OP_WR.
- Sub-module sram_fifo_obuf: the 2-entry output queue with push/pop/count.

Test Plan:
- Reset: hold rst for 2 cycles → wr_ready=1, rd_valid=0, level=0; sram_cen=1, sram_gwen=1, sram_wen=8'hFF.
- Single word: write 0xA5 at edge T with rd_ready=0.
  - Cycle T: cen=0, gwen=0, a=0, d=0xA5.
  - Cycle T+1: cen=0, gwen=1, a=0.
  - After edge T+2: rd_valid=1, rd_data=0xA5, level=1.
- Fill: hold wr_valid=1 with incrementing data and rd_ready=0 → exactly 514 words accepted, then wr_ready=0, level=514, almost_full=1. Draining returns 0..513 in order.
- Starve priority: obuf empty, 3 words in SRAM, wr_valid=1 → wr_ready=0 for one cycle and a read is issued (gwen=1); a write follows the next cycle.
- Wrap: stream 1500 words with random wr_valid/rd_ready → output sequence identical to input, pointers wrap past 511, level never exceeds 514.
- Reset mid-read: issue a read, then assert rst on the next edge → captured Q discarded, rd_valid=0, level=0, SRAM pins idle.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared defaults, SRAM pin encodings and the per-cycle operation type
// for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ALMOST_FULL = 480;
    localparam int DEPTH           = 2 ** DEF_ADDR_W;

    // SRAM controls are active low; the WEN values are per bit and replicated to the word width.
    localparam logic CEN_ON   = 1'b0;
    localparam logic GWEN_WR  = 1'b0;
    localparam logic WEN_ALL  = 1'b0;
    localparam logic WEN_NONE = 1'b1;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_RD,
        OP_WR
    } sram_op_e;

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry first-word-fall-through queue that catches SRAM read data;
// entry0 is always the head presented to the consumer.
module sram_fifo_obuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] pushData_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] headData_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] entry0_q, entry0_d;
    logic [DATA_W-1:0] entry1_q, entry1_d;
    logic [1:0]        count_q, count_d;
    logic              popEn;
    logic              pushEn;

    // Pop is applied first so a simultaneous push lands behind the surviving entry.
    always_comb begin
        popEn    = pop_i && (count_q != 2'd0);
        pushEn   = push_i && ((count_q != 2'd2) || popEn);
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (popEn) begin
            entry0_d = entry1_q;
            count_d  = count_q - 2'd1;
        end
        if (pushEn) begin
            if (count_d == 2'd0) begin
                entry0_d = pushData_i;
            end else begin
                entry1_d = pushData_i;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign headData_o = entry0_q;
    assign count_o    = count_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a single-port 512x8 SRAM macro: one SRAM operation per
// cycle, read-ahead into a 2-entry output buffer so rd_data falls through.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ALMOST_FULL = DEF_ALMOST_FULL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic [DATA_W-1:0] sram_wen,
    output logic              sram_gwen,
    output logic              sram_cen,
    input  logic [DATA_W-1:0] sram_q
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   sramCount_q, sramCount_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        obufCount;
    logic [1:0]        pending;
    logic              notFull;
    logic              starve;
    logic              canRead;
    sram_op_e          op;

    assign pending = obufCount + {1'b0, inflight_q};
    assign notFull = (sramCount_q != FULL_COUNT);
    assign starve  = (pending == 2'd0) && (sramCount_q != '0);
    assign canRead = (sramCount_q != '0) && (pending != 2'd2);

    // An empty consumer side always wins the port so the read pipeline never stalls behind writes.
    always_comb begin
        op = OP_IDLE;
        if (rst) begin
            op = OP_IDLE;
        end else if (starve) begin
            op = OP_RD;
        end else if (wr_valid && notFull) begin
            op = OP_WR;
        end else if (canRead) begin
            op = OP_RD;
        end
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        sramCount_d = sramCount_q;
        inflight_d  = 1'b0;
        sram_cen    = ~CEN_ON;
        sram_gwen   = ~GWEN_WR;
        sram_wen    = {DATA_W{WEN_NONE}};
        sram_a      = '0;
        sram_d      = '0;
        case (op)
            OP_WR: begin
                wrPtr_d     = wrPtr_q + ADDR_W'(1);
                sramCount_d = sramCount_q + (ADDR_W+1)'(1);
                sram_cen    = CEN_ON;
                sram_gwen   = GWEN_WR;
                sram_wen    = {DATA_W{WEN_ALL}};
                sram_a      = wrPtr_q;
                sram_d      = wr_data;
            end
            OP_RD: begin
                rdPtr_d     = rdPtr_q + ADDR_W'(1);
                sramCount_d = sramCount_q - (ADDR_W+1)'(1);
                inflight_d  = 1'b1;
                sram_cen    = CEN_ON;
                sram_a      = rdPtr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            sramCount_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            sramCount_q <= sramCount_d;
            inflight_q  <= inflight_d;
        end
    end

    // Q is only valid the cycle after a read edge, which is exactly when inflight_q is set.
    sram_fifo_obuf #(
        .DATA_W(DATA_W)
    ) outBuf (
        .clk       (clk),
        .rst       (rst),
        .push_i    (inflight_q),
        .pushData_i(sram_q),
        .pop_i     (rd_ready),
        .headData_o(rd_data),
        .count_o   (obufCount)
    );

    assign wr_ready    = rst || (notFull && !starve);
    assign rd_valid    = !rst && (obufCount != 2'd0);
    assign level       = rst ? '0 : ({1'b0, sramCount_q}
                                     + {{(ADDR_W+1){1'b0}}, inflight_q}
                                     + {{ADDR_W{1'b0}}, obufCount});
    assign almost_full = (int'(level) >= ALMOST_FULL);

endmodule
